// File: rtl/instr_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader_if
// Purpose  : Field-tuple handshake bundle feeding the instruction loader.
//            The master drives the decoded instruction fields and in_valid;
//            the slave (loader) returns in_ready.
// Revision : 1.0  initial release
// ============================================================================
interface instr_loader_if;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] cls;
   logic       md;
   logic [3:0] op_sel;
   logic       jb;
   logic       bc;
   logic [2:0] rd;
   logic [2:0] rsA;
   logic [2:0] rsB;

   modport master (
      output in_valid, cls, md, op_sel, jb, bc, rd, rsA, rsB,
      input  in_ready
   );

   modport slave (
      input  in_valid, cls, md, op_sel, jb, bc, rd, rsA, rsB,
      output in_ready
   );
endinterface : instr_loader_if
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader
// Purpose  : Packs instruction field tuples into 16-bit words and writes them
//            to consecutive instruction-memory addresses starting at a
//            latched base, for a latched number of words.
// Revision : 1.0  initial release
// ============================================================================
module instr_loader #(
   parameter int ADDR_W = 8
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              start,
   input  wire logic [ADDR_W-1:0] base_addr,
   input  wire logic [ADDR_W-1:0] length,
   input  wire logic              abort,
   instr_loader_if.slave          tup,
   output logic                   mem_we,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [15:0]            mem_wdata,
   output logic                   busy,
   output logic                   done,
   output logic                   enc_err,
   output logic [ADDR_W-1:0]      count
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;

   logic [1:0]        state;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] len;
   logic              accept;
   logic              is_jump;
   logic              bad_enc;
   logic              last_word;
   logic [15:0]       word;

   // The loader only takes tuples while loading; abort closes the door at once.
   assign tup.in_ready = (state == LOAD) && !abort;
   assign accept       = tup.in_valid && tup.in_ready;
   assign busy         = (state != IDLE);
   // DONE is only ever entered for one cycle, so the pulse is the state itself.
   assign done         = (state == DONE);
   assign last_word    = (count == (len - ADDR_ONE));

   // Pack the field tuple; jump/branch words reuse the md/op_sel slots.
   always_comb begin
      is_jump = (tup.cls == 2'b11);
      bad_enc = is_jump && (tup.op_sel != 4'd0);
      word    = '0;
      word[15:14] = tup.cls;
      word[13]    = is_jump ? tup.jb : tup.md;
      word[12:10] = is_jump ? 3'b000 : tup.op_sel[3:1];
      word[9]     = is_jump ? tup.bc : tup.op_sel[0];
      word[8:6]   = tup.rd;
      word[5:3]   = tup.rsA;
      word[2:0]   = tup.rsB;
   end

   // Control FSM plus registered memory write port; an accepted tuple becomes
   // a write on the following cycle, and address wrap is deliberately silent.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         base      <= '0;
         len       <= '0;
         count     <= '0;
         enc_err   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  base    <= base_addr;
                  len     <= length;
                  count   <= '0;
                  enc_err <= 1'b0;
                  state   <= (length == ADDR_ZERO) ? DONE : LOAD;
               end
            end
            LOAD: begin
               if (abort) begin
                  state <= IDLE;
               end else if (accept) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= base + count;
                  mem_wdata <= word;
                  count     <= count + ADDR_ONE;
                  if (bad_enc) begin
                     enc_err <= 1'b1;
                  end
                  if (last_word) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule : instr_loader
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_loader
// Purpose  : Directed self-checking bench for instr_loader.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_loader;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] base_addr;
   logic [7:0] length;
   logic       abort;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [15:0] mem_wdata;
   logic       busy;
   logic       done;
   logic       enc_err;
   logic [7:0] count;

   int errors = 0;
   int checks = 0;

   instr_loader_if tup_if ();

   instr_loader #(.ADDR_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .abort     (abort),
      .tup       (tup_if),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .done      (done),
      .enc_err   (enc_err),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_tuple(input logic [1:0] c, input logic m, input logic [3:0] op,
                            input logic j, input logic b, input logic [2:0] d,
                            input logic [2:0] a, input logic [2:0] s);
      tup_if.cls    = c;
      tup_if.md     = m;
      tup_if.op_sel = op;
      tup_if.jb     = j;
      tup_if.bc     = b;
      tup_if.rd     = d;
      tup_if.rsA    = a;
      tup_if.rsB    = s;
   endtask

   task automatic do_start(input logic [7:0] b, input logic [7:0] l);
      start     = 1'b1;
      base_addr = b;
      length    = l;
      tick();
      start     = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; abort = 1'b0;
      tup_if.in_valid = 1'b0;
      set_tuple(2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
      #2;
      check_eq("reset_busy",  {31'd0, busy}, 32'd0);
      check_eq("reset_we",    {31'd0, mem_we}, 32'd0);
      check_eq("reset_ready", {31'd0, tup_if.in_ready}, 32'd0);
      check_eq("reset_count", {24'd0, count}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check_eq("idle_busy", {31'd0, busy}, 32'd0);

      // Register op, single word
      do_start(8'h10, 8'd1);
      check_eq("s1_busy", {31'd0, busy}, 32'd1);
      set_tuple(2'b00, 1'b0, 4'b0101, 1'b0, 1'b0, 3'd3, 3'd1, 3'd2);
      tup_if.in_valid = 1'b1;
      #1;
      check_eq("s1_ready", {31'd0, tup_if.in_ready}, 32'd1);
      tick();
      tup_if.in_valid = 1'b0;
      check_eq("s1_we",    {31'd0, mem_we}, 32'd1);
      check_eq("s1_addr",  {24'd0, mem_addr}, 32'h10);
      check_eq("s1_wdata", {16'd0, mem_wdata}, 32'h0ACA);
      check_eq("s1_done",  {31'd0, done}, 32'd1);
      check_eq("s1_count", {24'd0, count}, 32'd1);
      tick();
      check_eq("s1_idle",  {31'd0, busy}, 32'd0);
      check_eq("s1_we_off", {31'd0, mem_we}, 32'd0);
      check_eq("s1_done_off", {31'd0, done}, 32'd0);
      check_eq("s1_addr_hold", {24'd0, mem_addr}, 32'h10);
      check_eq("s1_wdata_hold", {16'd0, mem_wdata}, 32'h0ACA);

      // Jump encoding, no error
      do_start(8'h20, 8'd1);
      set_tuple(2'b11, 1'b0, 4'h0, 1'b1, 1'b0, 3'd0, 3'd4, 3'd0);
      tup_if.in_valid = 1'b1;
      tick();
      tup_if.in_valid = 1'b0;
      check_eq("s2_wdata", {16'd0, mem_wdata}, 32'hE020);
      check_eq("s2_addr",  {24'd0, mem_addr}, 32'h20);
      check_eq("s2_err",   {31'd0, enc_err}, 32'd0);
      tick();

      // Branch with non-zero op_sel: flagged but still written, error sticky
      do_start(8'h30, 8'd1);
      set_tuple(2'b11, 1'b0, 4'b0110, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0);
      tup_if.in_valid = 1'b1;
      tick();
      tup_if.in_valid = 1'b0;
      check_eq("s3_we",    {31'd0, mem_we}, 32'd1);
      check_eq("s3_wdata", {16'd0, mem_wdata}, 32'hC200);
      check_eq("s3_err",   {31'd0, enc_err}, 32'd1);
      tick();
      tick();
      check_eq("s3_err_hold", {31'd0, enc_err}, 32'd1);

      // Wrap-around burst with in_valid held; a start in LOAD is ignored
      do_start(8'hFE, 8'd3);
      check_eq("s4_err_clr", {31'd0, enc_err}, 32'd0);
      set_tuple(2'b10, 1'b1, 4'b1001, 1'b0, 1'b0, 3'd7, 3'd6, 3'd5);
      tup_if.in_valid = 1'b1;
      tick();
      check_eq("s4_addr0", {24'd0, mem_addr}, 32'hFE);
      check_eq("s4_wdata", {16'd0, mem_wdata}, 32'hB3F5);
      check_eq("s4_cnt0",  {24'd0, count}, 32'd1);
      start = 1'b1; base_addr = 8'h00; length = 8'd1;
      tick();
      start = 1'b0;
      check_eq("s4_we1",   {31'd0, mem_we}, 32'd1);
      check_eq("s4_addr1", {24'd0, mem_addr}, 32'hFF);
      check_eq("s4_done1", {31'd0, done}, 32'd0);
      tick();
      check_eq("s4_addr2", {24'd0, mem_addr}, 32'h00);
      check_eq("s4_done2", {31'd0, done}, 32'd1);
      check_eq("s4_cnt2",  {24'd0, count}, 32'd3);
      check_eq("s4_err",   {31'd0, enc_err}, 32'd0);
      check_eq("s4_ready_done", {31'd0, tup_if.in_ready}, 32'd0);
      tick();
      tup_if.in_valid = 1'b0;
      check_eq("s4_no_extra_we", {31'd0, mem_we}, 32'd0);
      check_eq("s4_idle", {31'd0, busy}, 32'd0);

      // Abort after two acceptances
      do_start(8'h40, 8'd4);
      tup_if.in_valid = 1'b1;
      tick();
      tick();
      check_eq("s5_addr1", {24'd0, mem_addr}, 32'h41);
      abort = 1'b1;
      #1;
      check_eq("s5_ready_abort", {31'd0, tup_if.in_ready}, 32'd0);
      check_eq("s5_we_pending",  {31'd0, mem_we}, 32'd1);
      tick();
      abort = 1'b0;
      tup_if.in_valid = 1'b0;
      check_eq("s5_we",    {31'd0, mem_we}, 32'd0);
      check_eq("s5_done",  {31'd0, done}, 32'd0);
      check_eq("s5_idle",  {31'd0, busy}, 32'd0);
      check_eq("s5_count", {24'd0, count}, 32'd2);
      tick();

      // Zero length (abort in IDLE has no effect)
      abort = 1'b1;
      do_start(8'h55, 8'd0);
      abort = 1'b0;
      check_eq("s6_done", {31'd0, done}, 32'd1);
      check_eq("s6_busy", {31'd0, busy}, 32'd1);
      check_eq("s6_we",   {31'd0, mem_we}, 32'd0);
      check_eq("s6_count", {24'd0, count}, 32'd0);
      tick();
      check_eq("s6_done_off", {31'd0, done}, 32'd0);
      check_eq("s6_idle", {31'd0, busy}, 32'd0);

      // Reset in the middle of a load
      do_start(8'h60, 8'd4);
      tup_if.in_valid = 1'b1;
      tick();
      check_eq("s7_we_before", {31'd0, mem_we}, 32'd1);
      rst = 1'b1;
      #1;
      check_eq("s7_we",    {31'd0, mem_we}, 32'd0);
      check_eq("s7_busy",  {31'd0, busy}, 32'd0);
      check_eq("s7_count", {24'd0, count}, 32'd0);
      check_eq("s7_addr",  {24'd0, mem_addr}, 32'd0);
      check_eq("s7_wdata", {16'd0, mem_wdata}, 32'd0);
      check_eq("s7_ready", {31'd0, tup_if.in_ready}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check_eq("s7_we_after",   {31'd0, mem_we}, 32'd0);
      check_eq("s7_busy_after", {31'd0, busy}, 32'd0);
      tup_if.in_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_instr_loader
`default_nettype wire
